alu_serial_ctrl: RTL and testbench

//  Sequencer for the bit-serial MIPS ALU datapath: owns the 1-bit slice (AND/OR/adder + b-invert mux).

---
 rtl/alu_serial_if.sv | 28 ++
 rtl/alu_serial_ctrl.sv | 154 +++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_if.sv
// Handshake and operand/result bundle between the multicycle control FSM and the
// bit-serial ALU sequencer.
interface alu_serial_if #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             binv;
    logic [IDXW-1:0]  bit_idx;

    modport master (
        output start, op, a, b,
        input  busy, done, result, zero, ovf, binv, bit_idx
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, zero, ovf, binv, bit_idx
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: latches an op and two operands, walks a 1-bit
// AND/OR/adder slice LSB->MSB, and reports result, zero and signed overflow.
module alu_serial_ctrl #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic         clk,
    input  logic         rst,
    alu_serial_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic             carry_r;
    logic             lt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             ovf_r;
    logic             binv_r;
    logic [IDXW-1:0]  bit_idx_r;

    logic [1:0]       slice_s;
    logic             b_bit_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_bit_s;
    logic             slt_bit_s;
    logic             is_arith_s;
    logic             inv_sel_s;

    // One slice evaluation: returns {carry_out, result_bit}; illegal codes yield 0.
    function automatic logic [1:0] slice_bit(input logic [2:0] opc, input logic ai,
                                             input logic bi, input logic ci);
        logic [1:0] r;
        r = 2'b00;
        case (opc)
            OP_AND:                 r = {1'b0, ai & bi};
            OP_OR:                  r = {1'b0, ai | bi};
            OP_ADD, OP_SUB, OP_SLT: r = {(ai & bi) | (ai & ci) | (bi & ci), ai ^ bi ^ ci};
            default:                r = 2'b00;
        endcase
        return r;
    endfunction

    // Slice datapath for the bit selected by bit_idx and the next result image.
    always_comb begin
        b_bit_s               = b_r[bit_idx_r] ^ binv_r;
        slice_s               = slice_bit(op_r, a_r[bit_idx_r], b_bit_s, carry_r);
        res_next_s            = result_r;
        res_next_s[bit_idx_r] = slice_s[0];
        last_bit_s            = (bit_idx_r == IDXW'(WIDTH - 1));
        // Sign of the difference corrected by subtract overflow gives signed less-than.
        slt_bit_s             = slice_s[0] ^ (carry_r ^ slice_s[1]);
        is_arith_s            = (op_r == OP_ADD) || (op_r == OP_SUB);
        inv_sel_s             = (bus.op == OP_SUB) || (bus.op == OP_SLT);
    end

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= 3'b000;
            carry_r   <= 1'b0;
            lt_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= '0;
            zero_r    <= 1'b0;
            ovf_r     <= 1'b0;
            binv_r    <= 1'b0;
            bit_idx_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    binv_r <= 1'b0;
                    if (bus.start) begin
                        a_r       <= bus.a;
                        b_r       <= bus.b;
                        op_r      <= bus.op;
                        binv_r    <= inv_sel_s;
                        carry_r   <= inv_sel_s;
                        result_r  <= '0;
                        zero_r    <= 1'b0;
                        ovf_r     <= 1'b0;
                        bit_idx_r <= '0;
                        busy_r    <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    result_r  <= res_next_s;
                    carry_r   <= slice_s[1];
                    bit_idx_r <= bit_idx_r + IDXW'(1);
                    if (last_bit_s) begin
                        if (op_r == OP_SLT) begin
                            lt_r  <= slt_bit_s;
                            state <= FIX;
                        end else begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            zero_r <= (res_next_s == '0);
                            ovf_r  <= is_arith_s & (carry_r ^ slice_s[1]);
                            state  <= DONE;
                        end
                    end
                end
                FIX: begin
                    result_r <= {{(WIDTH-1){1'b0}}, lt_r};
                    zero_r   <= ~lt_r;
                    ovf_r    <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done_r <= 1'b0;
                    binv_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.result  = result_r;
    assign bus.zero    = zero_r;
    assign bus.ovf     = ovf_r;
    assign bus.binv    = binv_r;
    assign bus.bit_idx = bit_idx_r;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: directed cases with literal results plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_alu_serial_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_tot  = 0;

    alu_serial_if #(.WIDTH(W), .IDXW(3)) bus ();

    alu_serial_ctrl #(.WIDTH(W), .IDXW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Expected {ovf, zero, result} straight from the arithmetic meaning of each op.
    function automatic logic [W+1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        logic [W-1:0] r;
        logic         v;
        r = '0;
        v = 1'b0;
        case (o)
            3'b000: r = x & y;
            3'b001: r = x | y;
            3'b010: begin r = x + y; v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]); end
            3'b110: begin r = x - y; v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]); end
            3'b111: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            default: r = '0;
        endcase
        return {v, (r == '0), r};
    endfunction

    // Transaction model: m_cnt counts edges since acceptance, done lands at m_lat.
    logic           m_act;
    int             m_cnt;
    int             m_lat;
    logic [W+1:0]   m_exp;
    logic           m_binv;
    logic [W-1:0]   m_res;
    logic           m_zero;
    logic           m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 1'b0; m_cnt <= 0; m_lat <= 0; m_exp <= '0;
            m_binv <= 1'b0; m_res <= '0; m_zero <= 1'b0; m_ovf <= 1'b0;
        end else if (!m_act) begin
            if (bus.start) begin
                m_act  <= 1'b1;
                m_cnt  <= 1;
                m_lat  <= (bus.op == 3'b111) ? W + 2 : W + 1;
                m_exp  <= model(bus.op, bus.a, bus.b);
                m_binv <= (bus.op == 3'b110) || (bus.op == 3'b111);
                m_res  <= '0;
                m_zero <= 1'b0;
                m_ovf  <= 1'b0;
            end
        end else if (m_cnt == m_lat) begin
            m_act  <= 1'b0;
            m_binv <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_lat) begin
                m_res  <= m_exp[W-1:0];
                m_zero <= m_exp[W];
                m_ovf  <= m_exp[W+1];
            end
        end
    end

    // Per-cycle comparison of every observable output against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
            chk("rst_result", 32'(bus.result), 32'd0);
            chk("rst_zero", 32'(bus.zero), 32'd0);
            chk("rst_ovf", 32'(bus.ovf), 32'd0);
            chk("rst_binv", 32'(bus.binv), 32'd0);
            chk("rst_bit_idx", 32'(bus.bit_idx), 32'd0);
        end else begin
            chk("busy", 32'(bus.busy), 32'(m_act && (m_cnt < m_lat)));
            chk("done", 32'(bus.done), 32'(m_act && (m_cnt == m_lat)));
            chk("binv", 32'(bus.binv), 32'(m_binv));
            chk("zero", 32'(bus.zero), 32'(m_zero));
            chk("ovf", 32'(bus.ovf), 32'(m_ovf));
            if (!m_act || (m_cnt == m_lat)) chk("result", 32'(bus.result), 32'(m_res));
            if (m_act && (m_cnt <= W)) chk("bit_idx", 32'(bus.bit_idx), 32'(m_cnt - 1));
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_act && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(m_act), 32'd0);
    endtask

    task automatic directed(input string nm, input logic [2:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] er, input logic ez,
                            input logic eo, input int elat, input bit glitch);
        int cyc;
        wait_idle();
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 30) begin
            if (glitch && cyc == 3) begin
                bus.start = 1'b1; bus.op = 3'b010; bus.a = 8'h11; bus.b = 8'h22;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk({nm, "_latency"}, 32'(cyc), 32'(elat));
        chk({nm, "_result"}, 32'(bus.result), 32'(er));
        chk({nm, "_zero"}, 32'(bus.zero), 32'(ez));
        chk({nm, "_ovf"}, 32'(bus.ovf), 32'(eo));
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
        #23;
        chk("por_result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        directed("add_7f_01", 3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 9, 1'b0);
        directed("sub_05_05", 3'b110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 9, 1'b0);
        directed("sub_80_01", 3'b110, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 9, 1'b0);
        directed("slt_fd_02", 3'b111, 8'hFD, 8'h02, 8'h01, 1'b0, 1'b0, 10, 1'b0);
        directed("slt_7f_80", 3'b111, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b0, 10, 1'b0);
        directed("and_f0_3c", 3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 9, 1'b0);
        directed("or_f0_3c", 3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 9, 1'b0);
        directed("illegal_011", 3'b011, 8'hA5, 8'h5A, 8'h00, 1'b1, 1'b0, 9, 1'b0);
        directed("add_glitch", 3'b010, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 9, 1'b1);

        // Abort an ADD at bit 4 with an asynchronous reset.
        wait_idle();
        bus.start = 1'b1; bus.op = 3'b010; bus.a = 8'h55; bus.b = 8'h0F;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.bit_idx !== 3'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit4", 32'(bus.bit_idx), 32'd4);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_bit_idx", 32'(bus.bit_idx), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        directed("add_after_rst", 3'b010, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 9, 1'b0);

        // Random traffic: start is also pulsed while busy and must be ignored.
        for (int i = 0; i < 800; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op    = 3'($urandom_range(0, 7));
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
